// File: rtl/sap_ram_loader.sv
// DATA_W x 2^ADDR_W SAP program RAM with post-reset clear sequencer and a valid/ready program-load port.
// Read data is registered (1 cycle, old word on read-during-write); load port stalls only via prog_ready.
module sap_ram_loader #(
  parameter int DATA_W         = 8,
  parameter int ADDR_W         = 4,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic              sysclk,
  input  logic              reset_n,
  input  logic              clken,
  input  logic              write,
  input  logic [ADDR_W-1:0] adr,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] value,
  input  logic              prog_mode,
  input  logic              prog_valid,
  input  logic [DATA_W-1:0] prog_data,
  output logic              prog_ready,
  output logic              prog_done,
  output logic              busy
);

  localparam int DEPTH = 1 << ADDR_W;

  localparam logic [1:0] ST_CLEAR = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_PROG  = 2'd2;

  localparam logic [1:0]        ST_RESET = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;
  localparam logic [ADDR_W-1:0] ADR_LAST = '1;

  logic [1:0]        state;
  logic [ADDR_W-1:0] clr_ptr;
  logic [ADDR_W-1:0] prog_ptr;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              mem_we;
  logic [ADDR_W-1:0] mem_wa;
  logic [DATA_W-1:0] mem_wd;
  logic              beat;

  assign busy       = (state != ST_RUN);
  assign prog_ready = (state == ST_PROG) && !prog_done;
  assign beat       = prog_valid && prog_ready;

  // Single write port shared by the clear sequencer, the CPU and the loader.
  always_comb begin
    mem_we = 1'b0;
    mem_wa = adr;
    mem_wd = data_in;
    case (state)
      ST_CLEAR: begin
        mem_we = 1'b1;
        mem_wa = clr_ptr;
        mem_wd = '0;
      end
      ST_RUN: begin
        mem_we = clken && write;
      end
      ST_PROG: begin
        mem_we = beat;
        mem_wa = prog_ptr;
        mem_wd = prog_data;
      end
      default: mem_we = 1'b0;
    endcase
  end

  // Array is deliberately left out of reset; the clear sequencer zeroes it instead.
  always_ff @(posedge sysclk) begin
    if (mem_we) begin
      mem[mem_wa] <= mem_wd;
    end
  end

  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      value <= '0;
    end else begin
      value <= mem[adr];
    end
  end

  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_RESET;
      clr_ptr   <= '0;
      prog_ptr  <= '0;
      prog_done <= 1'b0;
    end else begin
      case (state)
        ST_CLEAR: begin
          clr_ptr <= clr_ptr + 1'b1;
          if (clr_ptr == ADR_LAST) begin
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (prog_mode) begin
            state     <= ST_PROG;
            prog_ptr  <= '0;
            prog_done <= 1'b0;
          end
        end
        ST_PROG: begin
          if (beat) begin
            prog_ptr <= prog_ptr + 1'b1;
            if (prog_ptr == ADR_LAST) begin
              prog_done <= 1'b1;
            end
          end
          // prog_done is kept on exit so the host can still see a completed load.
          if (!prog_mode) begin
            state <= ST_RUN;
          end
        end
        default: state <= ST_RESET;
      endcase
    end
  end

endmodule
